// File: rtl/int_ctrl.sv
// Interrupt controller: per-source mask and edge/level mode with a pend register.
// A three-state FSM presents one fixed-priority cause to the CPU at a time and does not nest.
module int_ctrl #(
    parameter int          N_SRC    = 8,
    parameter logic [31:0] VEC_BASE = 32'h10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic             ack,
    input  logic             eoi,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             INTin,
    output logic [31:0]      INTnum
);

    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_nxt;
    logic [N_SRC-1:0] mask, edge_mode, pend, isr, irq_prev;
    logic [N_SRC-1:0] mask_nxt, edge_nxt, pend_nxt, isr_nxt;
    logic [ID_W-1:0]  id, id_nxt, cand;
    logic             cand_vld;
    logic             int_in_nxt;
    logic [31:0]      int_num_nxt;
    logic [N_SRC-1:0] wdata, w1c, ack_clr, id_hot, rise, edge_val;
    logic             ack_take;
    logic             unused_wdata;

    assign wdata        = cfg_wdata[N_SRC-1:0];
    assign unused_wdata = ^cfg_wdata[31:N_SRC];

    assign mask_nxt = (cfg_we && cfg_addr == 2'd0) ? wdata : mask;
    assign edge_nxt = (cfg_we && cfg_addr == 2'd1) ? wdata : edge_mode;
    assign w1c      = (cfg_we && cfg_addr == 2'd2) ? wdata : '0;

    always_comb begin
        id_hot     = '0;
        id_hot[id] = 1'b1;
    end

    assign ack_take = (state == REQ) && ack;
    assign ack_clr  = ack_take ? id_hot : '0;

    // Edge sources: a new rising edge beats any clear landing in the same cycle.
    assign rise     = irq & ~irq_prev;
    assign edge_val = rise | (pend & ~(w1c | ack_clr));
    assign pend_nxt = (edge_mode & edge_val) | (~edge_mode & irq);

    // Descending scan so the lowest pending+enabled index is the one kept.
    always_comb begin
        cand_vld = 1'b0;
        cand     = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend[i] && mask[i]) begin
                cand_vld = 1'b1;
                cand     = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        id_nxt      = id;
        int_in_nxt  = INTin;
        int_num_nxt = INTnum;
        isr_nxt     = isr;
        case (state)
            IDLE: begin
                int_in_nxt = 1'b0;
                if (cand_vld) begin
                    id_nxt      = cand;
                    int_in_nxt  = 1'b1;
                    int_num_nxt = VEC_BASE + 32'(cand);
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                // Withdrawal looks at the values this edge commits, so a release drops INTin at once.
                if (ack) begin
                    int_in_nxt = 1'b0;
                    isr_nxt    = id_hot;
                    state_nxt  = SERVICE;
                end else if (!(pend_nxt[id] && mask_nxt[id])) begin
                    int_in_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            SERVICE: begin
                int_in_nxt = 1'b0;
                if (eoi) begin
                    isr_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                int_in_nxt = 1'b0;
                isr_nxt    = '0;
                state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            id        <= '0;
            mask      <= '0;
            edge_mode <= '0;
            pend      <= '0;
            isr       <= '0;
            irq_prev  <= '0;
            INTin     <= 1'b0;
            INTnum    <= '0;
        end else begin
            state     <= state_nxt;
            id        <= id_nxt;
            mask      <= mask_nxt;
            edge_mode <= edge_nxt;
            pend      <= pend_nxt;
            isr       <= isr_nxt;
            irq_prev  <= irq;
            INTin     <= int_in_nxt;
            INTnum    <= int_num_nxt;
        end
    end

    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = 32'(mask);
            2'd1:    cfg_rdata = 32'(edge_mode);
            2'd2:    cfg_rdata = 32'(pend);
            default: cfg_rdata = 32'(isr);
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl; expected causes are queued by the stimulus and
// checked by a monitor each time INTin rises, register state checked inline.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        ack, eoi, cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata, INTnum;
    logic        INTin;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    logic        intin_q = 1'b0;

    int_ctrl #(.N_SRC(8), .VEC_BASE(32'h10)) dut (
        .clk(clk), .rst(rst), .irq(irq), .ack(ack), .eoi(eoi),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .INTin(INTin), .INTnum(INTnum)
    );

    always #5 clk = ~clk;

    // Monitor: every new request must match the oldest queued cause.
    always @(negedge clk) begin
        if (INTin && !intin_q) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL cause_unexpected: got INTnum=%h, none expected", INTnum);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (INTnum !== e) begin
                    mismatched++;
                    $display("FAIL cause: got INTnum=%h, expected %h", INTnum, e);
                end
            end
        end
        intin_q <= INTin;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        check(nm, cfg_rdata, exp);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq = v; tick(); irq = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; irq = '0; ack = 1'b0; eoi = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        #2;
        check("reset_intin", {31'b0, INTin}, 32'h0);
        check("reset_intnum", INTnum, 32'h0);
        rd(2'd0, "reset_mask", 32'h0);
        rd(2'd3, "reset_isr", 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Edge source 2: two-edge latency, ack moves it into service
        cfg_write(2'd0, 32'h04);
        cfg_write(2'd1, 32'h04);
        rd(2'd0, "mask_readback", 32'h04);
        exp_q.push_back(32'h12);
        pulse_irq(8'h04);
        check("edge_no_early_req", {31'b0, INTin}, 32'h0);
        tick();
        check("edge_req", {31'b0, INTin}, 32'h1);
        pulse_ack();
        check("edge_ack_intin", {31'b0, INTin}, 32'h0);
        rd(2'd3, "edge_ack_isr", 32'h04);
        rd(2'd2, "edge_ack_pend", 32'h0);
        pulse_eoi();
        rd(2'd3, "edge_eoi_isr", 32'h0);

        // W1C on the pending edge source withdraws the request
        exp_q.push_back(32'h12);
        pulse_irq(8'h04);
        tick();
        check("w1c_req", {31'b0, INTin}, 32'h1);
        cfg_write(2'd2, 32'h04);
        check("w1c_drop", {31'b0, INTin}, 32'h0);
        rd(2'd2, "w1c_pend", 32'h0);
        check("w1c_intnum_hold", INTnum, 32'h12);

        // Level mode, priority and re-service while held
        cfg_write(2'd0, 32'hFF);
        cfg_write(2'd1, 32'h00);
        exp_q.push_back(32'h14);
        irq = 8'h30;
        tick(); tick();
        check("lvl_req", {31'b0, INTin}, 32'h1);
        pulse_ack();
        rd(2'd3, "lvl_isr", 32'h10);
        exp_q.push_back(32'h14);
        pulse_eoi();
        tick();
        check("lvl_rereq", {31'b0, INTin}, 32'h1);
        pulse_ack();
        irq = 8'h20;
        exp_q.push_back(32'h15);
        pulse_eoi();
        tick();
        check("lvl_next", {31'b0, INTin}, 32'h1);
        pulse_ack();
        irq = 8'h00;
        pulse_eoi();
        tick();
        check("lvl_quiet", {31'b0, INTin}, 32'h0);

        // Level source 5 released before ack
        exp_q.push_back(32'h15);
        irq = 8'h20;
        tick(); tick();
        check("rel_req", {31'b0, INTin}, 32'h1);
        irq = 8'h00;
        tick();
        check("rel_drop", {31'b0, INTin}, 32'h0);
        rd(2'd3, "rel_isr", 32'h0);
        check("rel_intnum_hold", INTnum, 32'h15);

        // Edge source 3 in service; edge on source 1 accumulates
        cfg_write(2'd1, 32'h0A);
        exp_q.push_back(32'h13);
        pulse_irq(8'h08);
        tick();
        pulse_ack();
        rd(2'd3, "svc_isr", 32'h08);
        pulse_irq(8'h02);
        tick();
        check("svc_no_nest", {31'b0, INTin}, 32'h0);
        rd(2'd2, "svc_pend", 32'h02);
        exp_q.push_back(32'h11);
        pulse_eoi();
        check("svc_eoi_idle", {31'b0, INTin}, 32'h0);
        tick();
        check("svc_after_eoi", {31'b0, INTin}, 32'h1);
        pulse_ack();
        pulse_eoi();
        rd(2'd2, "svc_pend_clear", 32'h0);

        // Edge on source 0 coincident with its ack: set wins
        cfg_write(2'd0, 32'h01);
        cfg_write(2'd1, 32'h01);
        exp_q.push_back(32'h10);
        pulse_irq(8'h01);
        tick();
        ack = 1'b1; irq = 8'h01;
        tick();
        ack = 1'b0; irq = 8'h00;
        rd(2'd2, "setwin_pend", 32'h01);
        rd(2'd3, "setwin_isr", 32'h01);
        exp_q.push_back(32'h10);
        pulse_eoi();
        tick();
        check("setwin_reserve", {31'b0, INTin}, 32'h1);
        pulse_ack();
        pulse_eoi();

        // Asynchronous reset while in service
        cfg_write(2'd0, 32'h04);
        cfg_write(2'd1, 32'h04);
        exp_q.push_back(32'h12);
        pulse_irq(8'h04);
        tick();
        pulse_ack();
        rd(2'd3, "rst_pre_isr", 32'h04);
        rst = 1'b1;
        #1;
        check("rst_intin", {31'b0, INTin}, 32'h0);
        check("rst_intnum", INTnum, 32'h0);
        rd(2'd0, "rst_mask", 32'h0);
        rd(2'd1, "rst_edge", 32'h0);
        rd(2'd2, "rst_pend", 32'h0);
        rd(2'd3, "rst_isr", 32'h0);
        rst = 1'b0;
        tick();
        pulse_eoi();
        tick();
        rd(2'd3, "rst_eoi_isr", 32'h0);
        check("rst_eoi_intin", {31'b0, INTin}, 32'h0);

        tick(); tick();
        check("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
